rule_pattern_encoder: RTL
=========================

RULE_PATTERN_ENCODER -- requirements
Module: rule_pattern_encoder

Interface
REQ-001 SHALL have parameter N_IN, default 4: width of the rule-activation pattern.
REQ-002 SHALL have parameter CODE_W, default 2: width of the output code.
REQ-003 SHALL have parameter DEPTH, default 9: number of table entries; IDX_W = clog2(DEPTH).
REQ-004 SHALL have ports in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pattern offered.
- in_ready  out  1  block can accept a pattern.
- in_pattern  in  N_IN  activation pattern.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_code  out  CODE_W  encoded result.
- out_hit  out  1  1 = match found, 0 = no entry matched.
- out_index  out  IDX_W  index of the matching entry.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_W  entry to write.
- cfg_pattern  in  N_IN  pattern to store.
- cfg_code  in  CODE_W  code to store.
- cfg_clr  in  1  invalidate all entries.

Function
REQ-005 SHALL hold DEPTH entries {valid, pattern, code}; entry 0 has the highest priority, and the lowest-indexed valid exact match wins.
REQ-006 SHALL implement an FSM with states IDLE, SCAN and DONE; in_ready = (state == IDLE).
REQ-007 IDLE: when in_valid & in_ready, SHALL capture in_pattern, set idx to 0 and go to SCAN.
REQ-008 SCAN: each cycle SHALL compare entry idx with the captured pattern.
- Valid match: go to DONE with out_hit=1, out_code=entry code, out_index=idx.
- No match and idx == DEPTH-1: go to DONE with out_hit=0, out_code=0, out_index=0.
- Otherwise: idx <= idx+1.
REQ-009 Latency SHALL be k+1 cycles from the accept edge to out_valid for a match at entry k, and DEPTH cycles for a miss.
REQ-010 DONE: SHALL hold out_valid=1 with stable out_code, out_hit and out_index until out_valid & out_ready, then go to IDLE.
REQ-011 A new pattern SHALL be accepted no earlier than the cycle after the output handshake; there is no overlap between patterns.
REQ-012 out_code, out_hit and out_index SHALL be 0 whenever out_valid=0.
REQ-013 A cfg_we write SHALL update the entry at the clock edge and set its valid bit; writes are permitted in any state.
REQ-014 A comparison in the same cycle as a write to that entry SHALL use the pre-write contents.
REQ-015 A cfg_addr value >= DEPTH SHALL cause the write to be ignored.
REQ-016 cfg_clr SHALL clear all valid bits at the edge and takes priority over a cfg_we in the same cycle.
REQ-017 cfg_clr during SCAN SHALL let the scan continue against the cleared table, resulting in a miss unless an entry is rewritten ahead of idx.

Reset
REQ-018 On rst at the clock edge, SHALL go to IDLE with idx=0 and all outputs 0; in_ready=1 from the first cycle after reset.
REQ-019 rst during SCAN or DONE SHALL discard the pending pattern and result with no output handshake.
REQ-020 rst SHALL clear all table valid bits unless REQ-022 applies.

Configuration
REQ-021 Macro RULE_ENC_DEFAULT_TABLE_EN SHALL select the reset contents of the table.
REQ-022 With the macro defined, rst SHALL load entries 0..8 as valid and entries >= 9 as invalid, pattern->code:
- 0000->0, 0001->0, 0100->0
- 1000->1, 0101->1, 0010->1
- 1001->2, 0110->2, 1010->2
With the macro defined, N_IN SHALL be 4, CODE_W SHALL be >= 2 and DEPTH SHALL be >= 9, enforced by an elaboration-time check.
REQ-023 Without the macro, rst SHALL leave every entry invalid, so all lookups miss until the table is written.

Structure
REQ-024 Package rule_enc_pkg SHALL contain the FSM state enum and the default-table pattern/code constant arrays.
REQ-025 Table storage and the write/clear logic SHALL live in sub-module rule_table; rule_pattern_encoder contains the FSM and the compare logic.

Verification
REQ-026 Default table with the macro defined: in_pattern=1001 -> out_valid 7 cycles after accept, out_hit=1, out_code=2, out_index=6.
REQ-027 Default table with the macro defined: in_pattern=1111 -> out_valid 9 cycles after accept, out_hit=0, out_code=0.
REQ-028 Write entry 0 = {1001, 3}, then input 1001 -> out_code=3, out_index=0, latency 1 cycle (priority check).
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 and in_valid ignored; after out_ready=1, in_ready=1 on the next cycle.
REQ-030 Assert cfg_clr at scan idx=2 while looking up 1010 -> out_hit=0; assert rst mid-SCAN -> no out_valid and in_ready=1 on the cycle after reset.

Source files
------------

// File: rtl/rule_enc_pkg.sv
// Shared types and default rule table for rule_pattern_encoder.
// The default table contents are only loaded when RULE_ENC_DEFAULT_TABLE_EN is defined.
package rule_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_DEPTH  = 9;
    localparam int unsigned DEF_N_IN   = 4;
    localparam int unsigned DEF_CODE_W = 2;

    localparam logic [3:0] DEF_PATTERN [DEF_DEPTH] = '{
        4'b0000, 4'b0001, 4'b0100,
        4'b1000, 4'b0101, 4'b0010,
        4'b1001, 4'b0110, 4'b1010
    };

    localparam logic [1:0] DEF_CODE [DEF_DEPTH] = '{
        2'd0, 2'd0, 2'd0,
        2'd1, 2'd1, 2'd1,
        2'd2, 2'd2, 2'd2
    };

    // Default pattern for entry i; zero beyond the default table.
    function automatic logic [3:0] def_pattern(input int unsigned i);
        logic [3:0] v;
        v = '0;
        if (i < DEF_DEPTH) v = DEF_PATTERN[4'(i)];
        return v;
    endfunction

    // Default code for entry i; zero beyond the default table.
    function automatic logic [1:0] def_code(input int unsigned i);
        logic [1:0] v;
        v = '0;
        if (i < DEF_DEPTH) v = DEF_CODE[4'(i)];
        return v;
    endfunction

endpackage

// File: rtl/rule_pattern_encoder_table.sv
// rule_table: DEPTH-entry {valid, pattern, code} store with write, clear and one
// combinational read port. Reset contents selected by RULE_ENC_DEFAULT_TABLE_EN.
module rule_table
    import rule_enc_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned CODE_W = 2,
    parameter int unsigned DEPTH  = 9,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cfg_we,
    input  logic [IDX_W-1:0]  i_cfg_addr,
    input  logic [N_IN-1:0]   i_cfg_pattern,
    input  logic [CODE_W-1:0] i_cfg_code,
    input  logic              i_cfg_clr,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid_c,
    output logic [N_IN-1:0]   o_rd_pattern_c,
    output logic [CODE_W-1:0] o_rd_code_c
);

`ifdef RULE_ENC_DEFAULT_TABLE_EN
    // The default table only makes sense for 4-bit patterns and at least 9 entries.
    if (N_IN != DEF_N_IN || CODE_W < DEF_CODE_W || DEPTH < DEF_DEPTH) begin : g_cfg_check
        $error("rule_table: default table needs N_IN=4, CODE_W>=2, DEPTH>=9");
    end
`endif

    logic [DEPTH-1:0]  w_valid;
    logic [N_IN-1:0]   w_pattern [DEPTH];
    logic [CODE_W-1:0] w_code    [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic              r_valid;
        logic [N_IN-1:0]   r_pattern;
        logic [CODE_W-1:0] r_code;

        // Entry update: reset load, clear-all wins over a write, writes match only in-range addresses.
        always_ff @(posedge clk) begin
            if (rst) begin
`ifdef RULE_ENC_DEFAULT_TABLE_EN
                r_valid   <= (g < DEF_DEPTH);
                r_pattern <= N_IN'(def_pattern(g));
                r_code    <= CODE_W'(def_code(g));
`else
                r_valid   <= 1'b0;
                r_pattern <= '0;
                r_code    <= '0;
`endif
            end else if (i_cfg_clr) begin
                r_valid <= 1'b0;
            end else if (i_cfg_we && (i_cfg_addr == IDX_W'(g))) begin
                r_valid   <= 1'b1;
                r_pattern <= i_cfg_pattern;
                r_code    <= i_cfg_code;
            end
        end

        assign w_valid[g]   = r_valid;
        assign w_pattern[g] = r_pattern;
        assign w_code[g]    = r_code;
    end

    // Read port sees pre-edge contents, so a same-cycle write is not visible.
    assign o_rd_valid_c   = w_valid[i_rd_idx];
    assign o_rd_pattern_c = w_pattern[i_rd_idx];
    assign o_rd_code_c    = w_code[i_rd_idx];

endmodule

// File: rtl/rule_pattern_encoder.sv
// rule_pattern_encoder: sequential priority lookup of an activation pattern against
// a rule table, one entry per cycle, lowest matching index wins.
// Optional macro RULE_ENC_DEFAULT_TABLE_EN loads a default table on reset.
module rule_pattern_encoder
    import rule_enc_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned CODE_W = 2,
    parameter int unsigned DEPTH  = 9,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_pattern,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_hit,
    output logic [IDX_W-1:0]  out_index,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [N_IN-1:0]   cfg_pattern,
    input  logic [CODE_W-1:0] cfg_code,
    input  logic              cfg_clr
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [N_IN-1:0]   r_pat;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_code;
    logic              r_out_hit;
    logic [IDX_W-1:0]  r_out_index;

    state_t            w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [N_IN-1:0]   w_pat_nxt;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;
    logic [CODE_W-1:0] w_out_code_nxt;
    logic              w_out_hit_nxt;
    logic [IDX_W-1:0]  w_out_index_nxt;

    logic              w_rd_valid;
    logic [N_IN-1:0]   w_rd_pattern;
    logic [CODE_W-1:0] w_rd_code;
    logic              w_match;

    rule_table #(
        .N_IN   (N_IN),
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk            (clk),
        .rst            (rst),
        .i_cfg_we       (cfg_we),
        .i_cfg_addr     (cfg_addr),
        .i_cfg_pattern  (cfg_pattern),
        .i_cfg_code     (cfg_code),
        .i_cfg_clr      (cfg_clr),
        .i_rd_idx       (r_idx),
        .o_rd_valid_c   (w_rd_valid),
        .o_rd_pattern_c (w_rd_pattern),
        .o_rd_code_c    (w_rd_code)
    );

    assign w_match = w_rd_valid && (w_rd_pattern == r_pat);

    // State and registered outputs; reset drops any pending lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_pat       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_hit   <= 1'b0;
            r_out_index <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_pat       <= w_pat_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_code  <= w_out_code_nxt;
            r_out_hit   <= w_out_hit_nxt;
            r_out_index <= w_out_index_nxt;
        end
    end

    // Next-state and next-output logic: accept, scan one entry per cycle, hold result.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_pat_nxt       = r_pat;
        w_out_valid_nxt = r_out_valid;
        w_out_code_nxt  = r_out_code;
        w_out_hit_nxt   = r_out_hit;
        w_out_index_nxt = r_out_index;

        case (r_state)
            ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_pat_nxt   = in_pattern;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_match) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_out_hit_nxt   = 1'b1;
                    w_out_code_nxt  = w_rd_code;
                    w_out_index_nxt = r_idx;
                end else if (r_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_out_hit_nxt   = 1'b0;
                    w_out_code_nxt  = '0;
                    w_out_index_nxt = '0;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                    w_out_hit_nxt   = 1'b0;
                    w_out_code_nxt  = '0;
                    w_out_index_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
                w_out_hit_nxt   = 1'b0;
                w_out_code_nxt  = '0;
                w_out_index_nxt = '0;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_hit   = r_out_hit;
    assign out_index = r_out_index;

endmodule
